// File: rtl/control_sequencer.sv
// Hardwired Moore control sequencer: fetch (PC->MAR, MDR->IR), decode, per-opcode T3..T7 steps.
// Latency: fetch 3 cycles + memory waits; execute 0 (NOP), 3 (R-type/ADDI), 4 (MUL), 5 (LD/ST) + waits.
// Backpressure: mem_ready=0 holds the FSM in T1/T6(LD)/T7(ST) with strobes steady. Optional MUL via CTRL_MUL_EN.
module control_sequencer (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic [15:0] r_in,
    output logic        PC_in,
    output logic        IR_in,
    output logic        Y_in,
    output logic        Z_in,
    output logic        HI_in,
    output logic        LO_in,
    output logic        MAR_in,
    output logic        MDR_in,
    output logic [4:0]  bus_sel,
    output logic [4:0]  ALU_select,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        run,
    output logic        illegal
);

    // Opcodes; the ALU opcodes double as their ALU_select codes.
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_INC = 5'b11001;

    localparam logic [4:0] BUS_HI  = 5'd16;
    localparam logic [4:0] BUS_ZHI = 5'd18;
    localparam logic [4:0] BUS_ZLO = 5'd19;
    localparam logic [4:0] BUS_PC  = 5'd20;
    localparam logic [4:0] BUS_MDR = 5'd21;
    localparam logic [4:0] BUS_C   = 5'd23;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;

    logic [4:0] op;
    logic [3:0] ra, rb, rc;
    logic       op_rtype, op_imm, op_mul, op_legal;
    logic       unused_ir;

    assign op = ir[31:27];
    assign ra = ir[26:23];
    assign rb = ir[22:19];
    assign rc = ir[18:15];
    // Low bits carry the constant C, which reaches the datapath directly.
    assign unused_ir = ^{ir[14:0], BUS_HI};

    // Opcode class decode; MUL only exists when the multiplier is built in.
    always_comb begin
        op_rtype = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
        op_imm   = (op == OP_ADDI) || (op == OP_LD) || (op == OP_ST);
`ifdef CTRL_MUL_EN
        op_mul   = (op == OP_MUL);
`else
        op_mul   = 1'b0;
`endif
        op_legal = op_rtype || op_imm || op_mul || (op == OP_NOP) || (op == OP_HALT);
    end

    // State and sticky illegal flag; clr drops everything to RST at once.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q   <= S_RST;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state and control outputs; every output defaults to 0.
    always_comb begin
        state_d    = state_q;
        illegal_d  = illegal_q;
        r_in       = 16'h0000;
        PC_in      = 1'b0;
        IR_in      = 1'b0;
        Y_in       = 1'b0;
        Z_in       = 1'b0;
        HI_in      = 1'b0;
        LO_in      = 1'b0;
        MAR_in     = 1'b0;
        MDR_in     = 1'b0;
        bus_sel    = 5'd0;
        ALU_select = 5'd0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        run        = (state_q != S_RST) && (state_q != S_HALT);
        illegal    = illegal_q;

        case (state_q)
            S_RST: begin
                state_d = S_T0;
            end
            // PC -> MAR, Z <- PC+1
            S_T0: begin
                bus_sel    = BUS_PC;
                MAR_in     = 1'b1;
                ALU_select = ALU_INC;
                Z_in       = 1'b1;
                state_d    = S_T1;
            end
            // Read strobe held; PC updated from Z only on the completing cycle.
            S_T1: begin
                bus_sel = BUS_ZLO;
                mem_rd  = 1'b1;
                MDR_in  = 1'b1;
                PC_in   = mem_ready;
                if (mem_ready) begin
                    state_d = S_T2;
                end
            end
            // MDR -> IR and dispatch on the opcode.
            S_T2: begin
                bus_sel = BUS_MDR;
                IR_in   = 1'b1;
                if (op == OP_NOP) begin
                    state_d = S_T0;
                end else if (op == OP_HALT) begin
                    state_d = S_HALT;
                end else if (op_legal) begin
                    state_d = S_T3;
                end else begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end
            end
            // First operand into Y (Ra for MUL, Rb otherwise).
            S_T3: begin
                bus_sel = op_mul ? {1'b0, ra} : {1'b0, rb};
                Y_in    = 1'b1;
                state_d = S_T4;
            end
            // ALU step into Z.
            S_T4: begin
                Z_in    = 1'b1;
                state_d = S_T5;
                if (op_rtype) begin
                    bus_sel    = {1'b0, rc};
                    ALU_select = op;
                end else if (op_mul) begin
                    bus_sel    = {1'b0, rb};
                    ALU_select = OP_MUL;
                end else begin
                    bus_sel    = BUS_C;
                    ALU_select = ALU_ADD;
                end
            end
            // ZLO to register, MAR (address) or LO.
            S_T5: begin
                bus_sel = BUS_ZLO;
                if (op_rtype || (op == OP_ADDI)) begin
                    r_in    = 16'h0001 << ra;
                    state_d = S_T0;
                end else if (op_mul) begin
                    LO_in   = 1'b1;
                    state_d = S_T6;
                end else if ((op == OP_LD) || (op == OP_ST)) begin
                    MAR_in  = 1'b1;
                    state_d = S_T6;
                end else begin
                    state_d = S_T0;
                end
            end
            // LD read (waits), ST data into MDR, or ZHI into HI.
            S_T6: begin
                if (op == OP_LD) begin
                    mem_rd = 1'b1;
                    MDR_in = 1'b1;
                    if (mem_ready) begin
                        state_d = S_T7;
                    end
                end else if (op == OP_ST) begin
                    bus_sel = {1'b0, ra};
                    MDR_in  = 1'b1;
                    state_d = S_T7;
                end else if (op_mul) begin
                    bus_sel = BUS_ZHI;
                    HI_in   = 1'b1;
                    state_d = S_T0;
                end else begin
                    state_d = S_T0;
                end
            end
            // LD writeback, or ST write strobe held until memory completes.
            S_T7: begin
                if (op == OP_LD) begin
                    bus_sel = BUS_MDR;
                    r_in    = 16'h0001 << ra;
                    state_d = S_T0;
                end else if (op == OP_ST) begin
                    mem_wr = 1'b1;
                    if (mem_ready) begin
                        state_d = S_T0;
                    end
                end else begin
                    state_d = S_T0;
                end
            end
            // Parked until clr.
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_RST;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: reset, fetch waits, ADD, LD/ST, MUL, NOP, HALT, illegal.
// Expected values are hand-derived from the instruction encodings (op[31:27] Ra[26:23] Rb[22:19] Rc[18:15]).
// Inputs change 1 ns after the rising edge; outputs are sampled at that point.
module tb_control_sequencer;

    logic        clk;
    logic        clr;
    logic [31:0] ir;
    logic        mem_ready;
    logic [15:0] r_in;
    logic        PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in;
    logic [4:0]  bus_sel, ALU_select;
    logic        mem_rd, mem_wr, run, illegal;

    int checks   = 0;
    int failures = 0;

    control_sequencer dut (
        .clk        (clk),
        .clr        (clr),
        .ir         (ir),
        .mem_ready  (mem_ready),
        .r_in       (r_in),
        .PC_in      (PC_in),
        .IR_in      (IR_in),
        .Y_in       (Y_in),
        .Z_in       (Z_in),
        .HI_in      (HI_in),
        .LO_in      (LO_in),
        .MAR_in     (MAR_in),
        .MDR_in     (MDR_in),
        .bus_sel    (bus_sel),
        .ALU_select (ALU_select),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .run        (run),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // From T0 with zero-wait memory: T1, T2 (instruction presented), then the post-dispatch state.
    task automatic fetch(input logic [31:0] instr);
        tick();
        chk("fetch_T1_pc_in", {31'd0, PC_in}, 32'd1);
        tick();
        ir = instr;
        chk("fetch_T2_ir_in", {31'd0, IR_in}, 32'd1);
        tick();
    endtask

    initial begin
        clr       = 1'b0;
        ir        = 32'h0;
        mem_ready = 1'b0;
        #2;
        chk("rst_run",     {31'd0, run},     32'd0);
        chk("rst_bus_sel", {27'd0, bus_sel}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        clr = 1'b1;
        tick();
        chk("t0_bus_sel", {27'd0, bus_sel},    32'd20);
        chk("t0_mar_in",  {31'd0, MAR_in},     32'd1);
        chk("t0_alu_inc", {27'd0, ALU_select}, 32'd25);
        chk("t0_run",     {31'd0, run},        32'd1);

        // Asynchronous clr while waiting in T1.
        tick();
        chk("t1_mem_rd", {31'd0, mem_rd}, 32'd1);
        chk("t1_pc_in_wait", {31'd0, PC_in}, 32'd0);
        clr = 1'b0;
        #1;
        chk("clr_mid_t1_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("clr_mid_t1_run",    {31'd0, run},    32'd0);
        clr = 1'b1;
        tick();
        chk("restart_t0_bus_sel", {27'd0, bus_sel}, 32'd20);
        chk("restart_t0_mar_in",  {31'd0, MAR_in},  32'd1);

        // ADD R1,R2,R3 = 0x18918000, fetched with two wait cycles.
        ir = 32'h18918000;
        tick();
        chk("wait1_mem_rd", {31'd0, mem_rd}, 32'd1);
        chk("wait1_pc_in",  {31'd0, PC_in},  32'd0);
        tick();
        chk("wait2_mem_rd", {31'd0, mem_rd}, 32'd1);
        chk("wait2_pc_in",  {31'd0, PC_in},  32'd0);
        mem_ready = 1'b1;
        #1;
        chk("wait3_pc_in",  {31'd0, PC_in},  32'd1);
        tick();
        chk("add_t2_bus_sel", {27'd0, bus_sel}, 32'd21);
        chk("add_t2_pc_in",   {31'd0, PC_in},   32'd0);
        tick();
        chk("add_t3_bus_sel", {27'd0, bus_sel}, 32'd2);
        chk("add_t3_y_in",    {31'd0, Y_in},    32'd1);
        tick();
        chk("add_t4_bus_sel", {27'd0, bus_sel},    32'd3);
        chk("add_t4_alu",     {27'd0, ALU_select}, 32'd3);
        chk("add_t4_z_in",    {31'd0, Z_in},       32'd1);
        tick();
        chk("add_t5_bus_sel", {27'd0, bus_sel}, 32'd19);
        chk("add_t5_r_in",    {16'd0, r_in},    32'h0002);
        tick();
        chk("add_back_t0", {31'd0, MAR_in}, 32'd1);

        // LD R4,5(R2) = 0x02100005
        fetch(32'h02100005);
        chk("ld_t3_bus_sel", {27'd0, bus_sel}, 32'd2);
        tick();
        chk("ld_t4_bus_sel", {27'd0, bus_sel},    32'd23);
        chk("ld_t4_alu",     {27'd0, ALU_select}, 32'd3);
        tick();
        chk("ld_t5_mar_in",  {31'd0, MAR_in},  32'd1);
        chk("ld_t5_bus_sel", {27'd0, bus_sel}, 32'd19);
        mem_ready = 1'b0;
        tick();
        chk("ld_t6_mem_rd", {31'd0, mem_rd}, 32'd1);
        chk("ld_t6_mdr_in", {31'd0, MDR_in}, 32'd1);
        tick();
        chk("ld_t6_wait_mem_rd", {31'd0, mem_rd}, 32'd1);
        mem_ready = 1'b1;
        tick();
        chk("ld_t7_r_in",    {16'd0, r_in},    32'h0010);
        chk("ld_t7_bus_sel", {27'd0, bus_sel}, 32'd21);
        chk("ld_t7_mem_rd",  {31'd0, mem_rd},  32'd0);
        tick();
        chk("ld_back_t0", {27'd0, bus_sel}, 32'd20);

        // ST R4,5(R2) = 0x0A100005
        fetch(32'h0A100005);
        tick();
        tick();
        chk("st_t5_mar_in", {31'd0, MAR_in}, 32'd1);
        mem_ready = 1'b0;
        tick();
        chk("st_t6_bus_sel", {27'd0, bus_sel}, 32'd4);
        chk("st_t6_mdr_in",  {31'd0, MDR_in},  32'd1);
        tick();
        chk("st_t7_mem_wr", {31'd0, mem_wr}, 32'd1);
        tick();
        chk("st_t7_wait_mem_wr", {31'd0, mem_wr}, 32'd1);
        mem_ready = 1'b1;
        tick();
        chk("st_back_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("st_back_t0",     {31'd0, MAR_in}, 32'd1);

        // MUL R5,R6 = 0x7AB00000
        fetch(32'h7AB00000);
`ifdef CTRL_MUL_EN
        chk("mul_t3_bus_sel", {27'd0, bus_sel}, 32'd5);
        tick();
        chk("mul_t4_bus_sel", {27'd0, bus_sel},    32'd6);
        chk("mul_t4_alu",     {27'd0, ALU_select}, 32'd15);
        tick();
        chk("mul_t5_lo_in",   {31'd0, LO_in},   32'd1);
        chk("mul_t5_bus_sel", {27'd0, bus_sel}, 32'd19);
        tick();
        chk("mul_t6_hi_in",   {31'd0, HI_in},   32'd1);
        chk("mul_t6_bus_sel", {27'd0, bus_sel}, 32'd18);
        tick();
        chk("mul_back_t0", {31'd0, MAR_in}, 32'd1);
        chk("mul_illegal", {31'd0, illegal}, 32'd0);
`else
        chk("mul_off_run",     {31'd0, run},     32'd0);
        chk("mul_off_illegal", {31'd0, illegal}, 32'd1);
        chk("mul_off_hi_in",   {31'd0, HI_in},   32'd0);
        clr = 1'b0;
        #1;
        chk("mul_off_clr_illegal", {31'd0, illegal}, 32'd0);
        clr = 1'b1;
        tick();
        chk("mul_off_restart_t0", {31'd0, MAR_in}, 32'd1);
`endif

        // NOP = 0xD0000000: straight back to T0 after T2.
        fetch(32'hD0000000);
        chk("nop_t0_bus_sel", {27'd0, bus_sel}, 32'd20);

        // Undefined opcode 10101 = 0xA8000000: HALT with sticky illegal.
        fetch(32'hA8000000);
        chk("ill_run",     {31'd0, run},     32'd0);
        chk("ill_illegal", {31'd0, illegal}, 32'd1);
        mem_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("ill_hold_run",     {31'd0, run},     32'd0);
            chk("ill_hold_illegal", {31'd0, illegal}, 32'd1);
            chk("ill_hold_enables", {r_in, 1'b0, mem_rd, MAR_in, MDR_in, IR_in, Y_in, Z_in, PC_in, 3'd0, bus_sel}, 32'd0);
        end
        clr = 1'b0;
        #1;
        chk("ill_clr_illegal", {31'd0, illegal}, 32'd0);
        clr = 1'b1;
        mem_ready = 1'b1;
        tick();
        chk("ill_restart_t0", {27'd0, bus_sel}, 32'd20);

        // HALT = 0xD8000000: stops without flagging illegal.
        fetch(32'hD8000000);
        chk("halt_run",     {31'd0, run},     32'd0);
        chk("halt_illegal", {31'd0, illegal}, 32'd0);
        tick();
        chk("halt_stays", {31'd0, run}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
